// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - boot-time SPI flash READ burst copier into instruction RAM
module flash_loader #(
  parameter int          CLK_DIV    = 2,
  parameter int          WORDS      = 2048,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        spi_sck_o,
  output logic        spi_cs_no,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        write_o,
  output logic [12:0] addr_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [10:0] LAST_WORD = 11'(WORDS - 1);
  localparam logic [12:0] LAST_ADDR = {LAST_WORD, 2'b00};
  localparam logic [7:0]  READ_CMD  = 8'h03;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [30:0] rx_q, rx_d;
  logic [10:0] word_q, word_d;
  logic [12:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic        active;
  logic        tick;
  logic        sck_rise;
  logic        sck_fall;
  logic [31:0] rx_word;

  // SCK runs only while the transaction is open; edges are qualified by the divider tick
  assign active   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  assign tick     = (div_q == DIV_LAST);
  assign sck_rise = active && tick && !sck_q;
  assign sck_fall = active && tick && sck_q;
  // Received word including the bit being sampled this cycle; first bit ends up at [31]
  assign rx_word  = {rx_q, spi_miso_i};

  // Next-state and datapath: command/address shifted out on falling edges, data sampled on rising edges
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    write_d = 1'b0;
    done_d  = done_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (active) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      if (tick) begin
        sck_d = ~sck_q;
      end
    end

    case (state_q)
      IDLE: begin
        state_d = CMD;
        cs_n_d  = 1'b0;
        tx_d    = {READ_CMD, FLASH_BASE};
        div_d   = 8'd0;
        sck_d   = 1'b0;
        bit_d   = 5'd0;
        word_d  = 11'd0;
      end
      CMD, ADDR: begin
        if (sck_fall) begin
          tx_d  = {tx_q[30:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            state_d = ADDR;
          end
          if (bit_q == 5'd31) begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (write_q && (addr_q == LAST_ADDR)) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          sck_d   = 1'b0;
          div_d   = 8'd0;
        end else if (sck_rise) begin
          rx_d  = rx_word[30:0];
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            write_d = 1'b1;
            addr_d  = {word_q, 2'b00};
            data_d  = {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
            if (word_q != LAST_WORD) begin
              word_d = word_q + 11'd1;
            end
          end
        end
      end
      DONE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer and closes the chip select at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= 5'd0;
      tx_q    <= 32'd0;
      rx_q    <= 31'd0;
      word_q  <= 11'd0;
      addr_q  <= 13'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      write_q <= write_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign spi_sck_o  = sck_q;
  assign spi_cs_no  = cs_n_q;
  assign spi_mosi_o = ((state_q == CMD) || (state_q == ADDR)) ? tx_q[31] : 1'b0;
  assign write_o    = write_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign busy_o     = active;
  assign done_o     = done_q;

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - self-checking bench for flash_loader with a behavioural SPI flash
module tb_flash_loader;

  localparam int          DIV_A   = 2;
  localparam int          WORDS_A = 4;
  localparam int          DIV_B   = 1;
  localparam int          WORDS_B = 1;
  localparam int          DIV_C   = 3;
  localparam int          WORDS_C = 128;
  localparam logic [23:0] BASE_C  = 24'h100000;

  typedef struct {
    int          idx;
    logic [12:0] addr;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n  = 3'b000;
  logic [2:0]  miso_r = 3'b010;
  logic [2:0]  sck, cs_n, mosi, wr, busy, done;
  logic [12:0] addr_w [3];
  logic [31:0] data_w [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // flash model / monitor state, written only by the monitor process
  int          wcnt [3];
  int          rises [3];
  int          cs_err [3];
  int          wr_err [3];
  int          per_min [3];
  int          per_max [3];
  int          last_rise [3];
  int          last_wr_cyc [3];
  int          cs_rise_cyc [3];
  int          done_rise_cyc [3];
  logic [31:0] cap [3];
  logic [44:0] wlog [3][2048];
  logic [2:0]  sck_p  = 3'b000;
  logic [2:0]  cs_p   = 3'b111;
  logic [2:0]  wr_p   = 3'b000;
  logic [2:0]  done_p = 3'b000;

  logic [7:0]  mem2 [1024];
  vec_t        tbl [4];

  flash_loader #(.CLK_DIV(DIV_A), .WORDS(WORDS_A), .FLASH_BASE(24'h000000)) u_a (
    .clk_i(clk), .rst_ni(rst_n[0]), .spi_sck_o(sck[0]), .spi_cs_no(cs_n[0]),
    .spi_mosi_o(mosi[0]), .spi_miso_i(miso_r[0]), .write_o(wr[0]), .addr_o(addr_w[0]),
    .data_o(data_w[0]), .busy_o(busy[0]), .done_o(done[0]));

  flash_loader #(.CLK_DIV(DIV_B), .WORDS(WORDS_B), .FLASH_BASE(24'h000000)) u_b (
    .clk_i(clk), .rst_ni(rst_n[1]), .spi_sck_o(sck[1]), .spi_cs_no(cs_n[1]),
    .spi_mosi_o(mosi[1]), .spi_miso_i(miso_r[1]), .write_o(wr[1]), .addr_o(addr_w[1]),
    .data_o(data_w[1]), .busy_o(busy[1]), .done_o(done[1]));

  flash_loader #(.CLK_DIV(DIV_C), .WORDS(WORDS_C), .FLASH_BASE(BASE_C)) u_c (
    .clk_i(clk), .rst_ni(rst_n[2]), .spi_sck_o(sck[2]), .spi_cs_no(cs_n[2]),
    .spi_mosi_o(mosi[2]), .spi_miso_i(miso_r[2]), .write_o(wr[2]), .addr_o(addr_w[2]),
    .data_o(data_w[2]), .busy_o(busy[2]), .done_o(done[2]));

  always @(posedge clk) cyc <= cyc + 1;

  // flash contents: instance 0 returns the low address byte, instance 2 a random image
  function automatic logic [7:0] fbyte(input int i, input logic [23:0] a);
    if (i == 2) return mem2[a[9:0]];
    return a[7:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI flash model and write logger, evaluated on the falling clk edge
  always @(negedge clk) begin
    int idx;
    logic [7:0] fb;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        wcnt[i] = 0; rises[i] = 0; cs_err[i] = 0; wr_err[i] = 0;
        per_min[i] = 1 << 30; per_max[i] = 0; last_rise[i] = 0;
        last_wr_cyc[i] = 0; cs_rise_cyc[i] = 0; done_rise_cyc[i] = 0;
        cap[i] = 32'd0; miso_r[i] = 1'b0;
      end else begin
        if (sck[i] && !sck_p[i]) begin
          if (cs_n[i]) cs_err[i]++;
          if (rises[i] > 0) begin
            if (cyc - last_rise[i] < per_min[i]) per_min[i] = cyc - last_rise[i];
            if (cyc - last_rise[i] > per_max[i]) per_max[i] = cyc - last_rise[i];
          end
          last_rise[i] = cyc;
          if (rises[i] < 32) cap[i] = {cap[i][30:0], mosi[i]};
          rises[i]++;
        end
        if (!sck[i] && sck_p[i] && !cs_n[i] && rises[i] >= 32) begin
          idx = rises[i] - 32;
          fb = fbyte(i, cap[i][23:0] + 24'(idx / 8));
          miso_r[i] = fb[7 - (idx % 8)];
        end
        if (busy[i] && cs_n[i]) cs_err[i]++;
        if (wr[i]) begin
          if (wcnt[i] < 2048) wlog[i][wcnt[i]] = {addr_w[i], data_w[i]};
          wcnt[i]++;
          last_wr_cyc[i] = cyc;
          if (wr_p[i] || done[i]) wr_err[i]++;
        end
        if (cs_n[i] && !cs_p[i]) cs_rise_cyc[i] = cyc;
        if (done[i] && !done_p[i]) done_rise_cyc[i] = cyc;
      end
      if (i == 1) miso_r[i] = 1'b1;
    end
    sck_p = sck; cs_p = cs_n; wr_p = wr; done_p = done;
  end

  task automatic run_to_done(input int i, input int budget);
    int n = 0;
    while (!done[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_reached[%0d]", i), done[i], 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_run(input int i, input int words, input int div, input logic [23:0] base);
    chk($sformatf("write_count[%0d]", i), wcnt[i], words);
    chk($sformatf("cmd_addr_shift[%0d]", i), cap[i], {8'h03, base});
    chk($sformatf("sck_rises[%0d]", i), rises[i], 32 + 32 * words);
    chk($sformatf("sck_period_min[%0d]", i), per_min[i], 2 * div);
    chk($sformatf("sck_period_max[%0d]", i), per_max[i], 2 * div);
    chk($sformatf("cs_low_throughout[%0d]", i), cs_err[i], 0);
    chk($sformatf("write_single_not_after_done[%0d]", i), wr_err[i], 0);
    chk($sformatf("cs_rise_after_last_write[%0d]", i), cs_rise_cyc[i] - last_wr_cyc[i], 1);
    chk($sformatf("done_after_cs_rise[%0d]", i), done_rise_cyc[i] - cs_rise_cyc[i], 1);
    chk($sformatf("final_outputs[%0d]", i), {cs_n[i], sck[i], mosi[i], busy[i], done[i], wr[i]},
        6'b100010);
    if (wcnt[i] >= 1)
      chk($sformatf("last_addr[%0d]", i), wlog[i][wcnt[i] - 1][44:32], 13'((words - 1) * 4));
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    chk($sformatf("%s_cs_n[%0d]", tag, i), cs_n[i], 1);
    chk($sformatf("%s_sck[%0d]", tag, i), sck[i], 0);
    chk($sformatf("%s_mosi[%0d]", tag, i), mosi[i], 0);
    chk($sformatf("%s_write[%0d]", tag, i), wr[i], 0);
    chk($sformatf("%s_addr[%0d]", tag, i), addr_w[i], 0);
    chk($sformatf("%s_data[%0d]", tag, i), data_w[i], 0);
    chk($sformatf("%s_busy[%0d]", tag, i), busy[i], 0);
    chk($sformatf("%s_done[%0d]", tag, i), done[i], 0);
  endtask

  task automatic check_table(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_addr[%0d]", tag, tbl[k].idx), wlog[0][tbl[k].idx][44:32], tbl[k].addr);
      chk($sformatf("%s_data[%0d]", tag, tbl[k].idx), wlog[0][tbl[k].idx][31:0], tbl[k].data);
    end
  endtask

  initial begin
    int n;
    logic [31:0] exp_w;
    tbl[0] = '{0, 13'h000, 32'h03020100};
    tbl[1] = '{1, 13'h004, 32'h07060504};
    tbl[2] = '{2, 13'h008, 32'h0B0A0908};
    tbl[3] = '{3, 13'h00C, 32'h0F0E0D0C};
    for (int k = 0; k < 1024; k++) mem2[k] = 8'($urandom);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs(i, "reset");

    // incrementing-byte flash, CLK_DIV=2, four words
    rst_n[0] = 1'b1;
    run_to_done(0, 3000);
    check_run(0, WORDS_A, DIV_A, 24'h000000);
    check_table("A_run1");

    // restart, then abort in the middle of word 2
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    n = 0;
    while (wcnt[0] < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("A_reached_word2", wcnt[0], 2);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n[0] = 1'b0;
    #1 check_reset_outputs(0, "abort");
    repeat (4) @(negedge clk);
    chk("abort_no_write_in_reset", {wr[0], cs_n[0]}, 2'b01);
    rst_n[0] = 1'b1;
    run_to_done(0, 3000);
    check_run(0, WORDS_A, DIV_A, 24'h000000);
    check_table("A_restart");

    // constant-one MISO, fastest divider, single word
    rst_n[1] = 1'b1;
    run_to_done(1, 500);
    check_run(1, WORDS_B, DIV_B, 24'h000000);
    chk("B_addr", wlog[1][0][44:32], 13'h000);
    chk("B_data", wlog[1][0][31:0], 32'hFFFFFFFF);

    // random image at a nonzero base
    rst_n[2] = 1'b1;
    run_to_done(2, 30000);
    check_run(2, WORDS_C, DIV_C, BASE_C);
    for (int w = 0; w < WORDS_C; w++) begin
      exp_w = {mem2[4 * w + 3], mem2[4 * w + 2], mem2[4 * w + 1], mem2[4 * w]};
      chk($sformatf("C_addr[%0d]", w), wlog[2][w][44:32], 13'(w * 4));
      chk($sformatf("C_data[%0d]", w), wlog[2][w][31:0], exp_w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 2, SCK half-period in clk_i cycles; legal values 1-255.
REQ-002 The module SHALL have parameter WORDS, default 2048, number of 32-bit words copied; legal values 1-2048.
REQ-003 The module SHALL have parameter FLASH_BASE, default 24'h000000, first flash byte address read.
REQ-004 clk_i  input  1  sole clock; all state on its rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 spi_sck_o  output  1  SPI clock, mode 0 (idle low).
REQ-007 spi_cs_no  output  1  flash chip select, active low.
REQ-008 spi_mosi_o  output  1  serial data to flash.
REQ-009 spi_miso_i  input  1  serial data from flash.
REQ-010 write_o  output  1  one-cycle write strobe into the instruction RAM write port.
REQ-011 addr_o  output  13  byte address of the written word, bits [1:0] always 0.
REQ-012 data_o  output  32  word written, valid while write_o=1.
REQ-013 busy_o  output  1  high from leaving IDLE until entering DONE.
REQ-014 done_o  output  1  high once all WORDS words are written; holds the core in reset while low.

Function
REQ-015 The FSM SHALL have states IDLE, CMD, ADDR, DATA, DONE.
REQ-016 IDLE -> CMD SHALL occur on the first clk_i edge after rst_ni deasserts; no start input exists.
REQ-017 spi_cs_no SHALL go low on entry to CMD and stay low, without deassertion, until DATA completes.
REQ-018 SCK SHALL toggle every CLK_DIV clk_i cycles while in CMD, ADDR and DATA; it SHALL be low in IDLE and DONE, and its first edge after CS falls SHALL be rising.
REQ-019 CMD SHALL shift out 8'h03 (READ), MSB first; ADDR SHALL shift out FLASH_BASE, 24 bits, MSB first.
REQ-020 spi_mosi_o SHALL be valid before each SCK rising edge and change only on SCK falling edges or on CS falling; it SHALL be 0 in DATA, IDLE and DONE.
REQ-021 spi_miso_i SHALL be sampled on the clk_i cycle in which SCK rises, DATA state only.
REQ-022 DATA SHALL receive exactly 32*WORDS bits as one continuous burst, MSB first within each byte.
REQ-023 Byte k of each 4-byte group (k=0 first received) SHALL land in data_o[8k+7:8k] (little-endian).
REQ-024 write_o SHALL pulse for exactly one clk_i cycle, on the cycle after the 32nd bit of a word is sampled; addr_o SHALL equal word_index*4, word_index counting 0..WORDS-1.
REQ-025 addr_o and data_o SHALL hold their last values between strobes.
REQ-026 After the last word's write_o pulse, CS SHALL rise and SCK SHALL stop low on the next cycle, and the FSM SHALL enter DONE.
REQ-027 DONE SHALL be terminal until reset: done_o=1, busy_o=0, write_o=0.
REQ-028 The word counter SHALL be 11 bits and SHALL NOT wrap; reaching WORDS-1 ends DATA.
REQ-029 Total SCK rising edges per boot SHALL be 32+32*WORDS.

Reset
REQ-030 While rst_ni=0 (asynchronous): state=IDLE, spi_cs_no=1, spi_sck_o=0, spi_mosi_o=0, write_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0, all counters 0.
REQ-031 Reset asserted mid-operation SHALL abort immediately (CS high, no further write_o); after release the whole sequence restarts from CMD with word_index 0.

Verification
REQ-032 CLK_DIV=2, WORDS=4, flash model with bytes 00,01,02,...: -> writes (addr,data) = (0,32'h03020100),(4,32'h07060504),(8,32'h0B0A0908),(12,32'h0F0E0D0C); then done_o=1.
REQ-033 Capture MOSI on SCK rising edges -> first 32 bits = 32'h03000000; SCK period = 4 clk_i cycles; exactly 160 rising edges; CS low throughout, high after.
REQ-034 CLK_DIV=1, WORDS=1, MISO constant 1 -> single write (0,32'hFFFFFFFF); write_o high exactly one cycle; done_o rises one cycle after CS rises.
REQ-035 Assert rst_ni low during word 2 of a WORDS=4 run -> CS high and outputs at reset values same cycle; after release, writes restart at addr 0 with correct data.
REQ-036 FLASH_BASE=24'h100000, WORDS=2048 -> address phase shifts 24'h100000; last write addr_o=13'h1FFC; no write_o after done_o.
